// File: rtl/dt1_pkg.sv
// Shared types and constants for the dt1 register-file writeback path.
package dt1_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN_DEF = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE
    } arb_state_e;

endpackage

// File: rtl/dt1_starve_ctr.sv
// Saturating count of consecutive blocked cycles on the
// long-latency writeback port, with the force threshold.
module dt1_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic blk,
    output logic hit
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] THR = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !blk) begin
            cnt <= '0;
        end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = blk && (cnt == THR);

endmodule

// File: rtl/dt1_rf_wb_arbiter.sv
// Two-port writeback arbiter for the register file write port:
// fixed priority to the pipeline, forced grant for a starved port 1.
module dt1_rf_wb_arbiter
    import dt1_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              v0,
    output logic              rdy0,
    input  logic [REG_AW-1:0] a0,
    input  logic [XLEN-1:0]   d0,
    input  logic              v1,
    output logic              rdy1,
    input  logic [REG_AW-1:0] a1w,
    input  logic [XLEN-1:0]   d1,
    output logic              we3,
    output logic [REG_AW-1:0] a3,
    output logic [XLEN-1:0]   wd3,
    output logic              starved
);

    arb_state_e state;
    logic t0;
    logic t1;
    logic blk1;
    logic hit;

    assign rdy0 = !rst && !flush && (state == ARB_NORMAL);
    assign rdy1 = !rst && !flush && ((state == ARB_FORCE) || !v0);
    assign t0 = v0 && rdy0;
    assign t1 = v1 && rdy1;
    assign blk1 = v1 && !rdy1;
    assign starved = (state == ARB_FORCE);

    dt1_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .blk(blk1),
        .hit(hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_NORMAL;
        end else if (flush) begin
            state <= ARB_NORMAL;
        end else begin
            unique case (state)
                ARB_NORMAL: if (hit) state <= ARB_FORCE;
                ARB_FORCE: if (t1 || !v1) state <= ARB_NORMAL;
                default: state <= ARB_NORMAL;
            endcase
        end
    end

    // x0 requests complete the handshake but never raise we3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            a3  <= REG_ZERO;
            wd3 <= '0;
        end else begin
            unique case (1'b1)
                t0: begin
                    we3 <= (a0 != REG_ZERO);
                    a3  <= a0;
                    wd3 <= d0;
                end
                t1: begin
                    we3 <= (a1w != REG_ZERO);
                    a3  <= a1w;
                    wd3 <= d1;
                end
                default: we3 <= 1'b0;
            endcase
        end
    end

endmodule
